mem_stripe_loader: RTL and testbench
====================================

// Module: mem_stripe_loader
// PURPOSE
// Run-time loader for a bit-sliced instruction BRAM bank (NUM_MEM devices, DATA_W/NUM_MEM bits each).
// Accepts a word stream (e.g. from a boot UART), writes each word across all slices,
// zero-pads to the next INIT-group boundary, then reads back and checks a sum.
// Holds the CPU in reset while loading. Replaces static defparam init when images change post-synthesis.
// PARAMETERS
// DATA_W    32  CPU word width; must be divisible by NUM_MEM
// NUM_MEM   16  memory devices in the bank; slice width W = DATA_W/NUM_MEM
// MEM_SIZE  64  bank size in Kbytes; DEPTH = MEM_SIZE*256 words, AW = $clog2(DEPTH)
// VERIFY    1   1: run read-back checksum after load; 0: skip VERIFY state
// PORTS
// clk           in   1          system clock
// reset         in   1          synchronous, active-high reset
// start         in   1          pulse; begins a load, sampled in IDLE only
// num_words     in   AW+1       words to load, sampled with start
// s_data        in   DATA_W     stream word
// s_valid       in   1          stream word valid
// s_ready       out  1          loader accepts word this cycle
// mem_we        out  NUM_MEM    per-device write enable; all bits assert together
// mem_addr      out  AW         word address to all devices
// mem_wdata     out  DATA_W     device m receives mem_wdata[W*m +: W]
// mem_rdata     in   DATA_W     concatenated device read data, 1-cycle read latency
// cpu_hold      out  1          hold CPU in reset while loading
// busy          out  1          not IDLE
// done          out  1          one-cycle pulse on completion
// error         out  1          sticky until next start: size overflow or checksum mismatch
// checksum      out  32         sum mod 2^32 of accepted words
// BEHAVIOUR
// Reset: state=IDLE; s_ready, mem_we, busy, done, cpu_hold=0; error=0; checksum=0; counters=0.
// Reset mid-operation: abort immediately, no further writes, outputs at reset values.
// GROUP = 256/W words (one INIT_XX block per device); end = num_words rounded up to a multiple of GROUP.
// IDLE: start=1 -> clear error and checksum, latch num_words, go to LOAD, assert cpu_hold and busy.
//   num_words > DEPTH -> error=1, go to DONE, no writes. num_words=0 -> go to DONE, no writes.
// LOAD: s_ready=1 while cnt<num_words. Handshake = s_valid&&s_ready.
//   Write is registered: next cycle mem_we=all ones, mem_addr=cnt, mem_wdata=s_data.
//   checksum+=s_data; cnt++. Stalls without limit on !s_valid.
//   After the last accepted word, go to FILL if cnt<end, else to VERIFY/DONE.
// FILL: s_ready=0. One zero write per cycle at addr cnt until cnt==end. end is clamped to DEPTH.
// VERIFY: issue reads 0..end-1, one per cycle. Sum mem_rdata one cycle later.
//   Padding zeros do not change the sum. After the last read data returns: if sum!=checksum, error=1.
// DONE: done=1 for exactly one cycle; cpu_hold and busy drop the same cycle; then IDLE.
// start while busy is ignored. mem_we=0 outside LOAD/FILL writes. Address never exceeds DEPTH-1.
// Latency for N words with no stall, VERIFY=1: 1 + N + (end-N) + end + 2 cycles from start to done.
// TESTING
// 1. W=2 (16 devs), num_words=3, data 1,2,3 -> writes at addr 0..2, zero writes at 3..127.
//    checksum=6, done, error=0.
// 2. s_valid toggles every other cycle with 5 words -> no dropped or duplicated write.
//    mem_we only after handshakes.
// 3. num_words=DEPTH+1 -> error=1, done within 3 cycles, mem_we never asserted.
// 4. Bench model corrupts mem_rdata bit 0 at addr 1 during VERIFY -> error=1 with done pulse.
// 5. reset asserted mid-LOAD after 2 words -> next cycle: mem_we=0, busy=0, cpu_hold=0.
//    A fresh start then loads correctly.
// 6. Slice map: word 32'hC000_0003 -> device 0 slice=2'b11, device 15 slice=2'b11, all others 0.

Source files
------------

// File: rtl/mem_stripe_loader.sv
// Run-time loader for a bit-sliced instruction BRAM bank: streams words into every slice,
// zero-pads to the next INIT-group boundary, then optionally reads back and checks the sum.
module mem_stripe_loader #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_MEM  = 16,
  parameter  int MEM_SIZE = 64,
  parameter  int VERIFY   = 1,
  localparam int W        = DATA_W / NUM_MEM,
  localparam int DEPTH    = MEM_SIZE * 256,
  localparam int AW       = $clog2(DEPTH),
  localparam int GROUP    = 256 / W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [AW:0]        num_words,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [NUM_MEM-1:0] mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [31:0]        checksum
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_VERIFY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [AW:0]         num_q, num_d;
  logic [AW:0]         end_q, end_d;
  logic [31:0]         checksum_q, checksum_d;
  logic [31:0]         sum_q, sum_d;
  logic                error_q, error_d;
  logic                we_q, we_d;
  logic                rd1_q, rd1_d;
  logic                rd2_q, rd2_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [AW:0]         cnt_inc;
  state_t              after_write;

  // Round a word count up to a whole INIT group, never past the end of the bank.
  function automatic logic [AW:0] round_end(input logic [AW:0] n);
    logic [AW+1:0] r;
    r = {1'b0, n} + (AW+2)'(GROUP - 1);
    r = r & ~((AW+2)'(GROUP - 1));
    if (r > (AW+2)'(DEPTH)) r = (AW+2)'(DEPTH);
    return r[AW:0];
  endfunction

  assign s_ready   = (state_q == S_LOAD) && (cnt_q < num_q);
  assign mem_we    = {NUM_MEM{we_q}};
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_FILL) || (state_q == S_VERIFY);
  assign cpu_hold  = busy;
  assign done      = (state_q == S_DONE);
  assign error     = error_q;
  assign checksum  = checksum_q;

  assign cnt_inc     = cnt_q + 1'b1;
  assign after_write = (VERIFY != 0) ? S_VERIFY : S_DONE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    end_d      = end_q;
    checksum_d = checksum_q;
    error_d    = error_q;
    we_d       = 1'b0;
    rd1_d      = 1'b0;
    rd2_d      = rd1_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    // Read data lands two cycles after the read decision: one for the address flop, one for the BRAM.
    sum_d      = rd2_q ? (sum_q + 32'(mem_rdata)) : sum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d    = 1'b0;
          checksum_d = '0;
          sum_d      = '0;
          cnt_d      = '0;
          num_d      = num_words;
          end_d      = round_end(num_words);
          if (num_words > (AW+1)'(DEPTH)) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (num_words == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (s_valid && s_ready) begin
          we_d       = 1'b1;
          addr_d     = cnt_q[AW-1:0];
          wdata_d    = s_data;
          checksum_d = checksum_q + 32'(s_data);
          cnt_d      = cnt_inc;
          if (cnt_inc == num_q) begin
            if (cnt_inc < end_q) begin
              state_d = S_FILL;
            end else begin
              cnt_d   = '0;
              state_d = after_write;
            end
          end
        end
      end
      S_FILL: begin
        we_d    = 1'b1;
        addr_d  = cnt_q[AW-1:0];
        wdata_d = '0;
        cnt_d   = cnt_inc;
        if (cnt_inc == end_q) begin
          cnt_d   = '0;
          state_d = after_write;
        end
      end
      S_VERIFY: begin
        if (cnt_q < end_q) begin
          addr_d = cnt_q[AW-1:0];
          rd1_d  = 1'b1;
          cnt_d  = cnt_inc;
        end else if (!rd1_q && !rd2_q) begin
          if (sum_q != checksum_q) error_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      end_q      <= '0;
      checksum_q <= '0;
      error_q    <= 1'b0;
      we_q       <= 1'b0;
      rd1_q      <= 1'b0;
      rd2_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      end_q      <= end_d;
      checksum_q <= checksum_d;
      error_q    <= error_d;
      we_q       <= we_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    sum_q   <= sum_d;
  end

endmodule

// File: tb/tb_mem_stripe_loader.sv
// Directed bench for mem_stripe_loader: a behavioural BRAM bank with a write monitor and
// an optional read-data corruption on address 1.
module tb_mem_stripe_loader;
  localparam int DATA_W  = 32;
  localparam int NUM_MEM = 16;
  localparam int AW      = 14;
  localparam int DEPTH   = 16384;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [AW:0]        num_words;
  logic [DATA_W-1:0]  s_data;
  logic               s_valid;
  logic               s_ready;
  logic [NUM_MEM-1:0] mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic               cpu_hold, busy, done, error;
  logic [31:0]        checksum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   mem [0:DEPTH-1];
  int            wr_cnt, seq_err, part_err;
  logic [AW-1:0] exp_addr;
  logic [31:0]   first_wdata;
  logic          clr = 1'b0;
  logic          corrupt = 1'b0;
  logic [31:0]   words [0:7];
  int            done_cyc;
  bit            done_seen;

  mem_stripe_loader dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Bank model: writes when any enable is set, 1-cycle registered read, optional bit-0 flip at addr 1.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hFFFF_FFFF;
      wr_cnt   <= 0;
      seq_err  <= 0;
      part_err <= 0;
      exp_addr <= '0;
    end else if (|mem_we) begin
      if (mem_we !== {NUM_MEM{1'b1}}) part_err <= part_err + 1;
      if (mem_addr !== exp_addr) seq_err <= seq_err + 1;
      if (wr_cnt == 0) first_wdata <= mem_wdata;
      exp_addr       <= exp_addr + 1'b1;
      mem[mem_addr]  <= mem_wdata;
      wr_cnt         <= wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr] ^ {31'b0, (corrupt && mem_addr == 14'd1)};
  end

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_words = (AW+1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 500) begin
      s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data  = words[idx];
      #1;
      if (s_valid && s_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    n_checks++;
    if (idx != n) begin n_fail++; $display("FAIL send_words: accepted %0d required %0d", idx, n); end
  endtask

  task automatic wait_done();
    done_seen = 1'b0;
    done_cyc  = 0;
    while (!done && done_cyc < 2000) begin
      @(negedge clk);
      done_cyc++;
    end
    done_seen = done;
    n_checks++;
    if (!done_seen) begin n_fail++; $display("FAIL done_timeout: done=%0b after %0d cycles required 1", done, done_cyc); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; num_words = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({s_ready, |mem_we, busy, done, cpu_hold, error} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {s_ready, |mem_we, busy, done, cpu_hold, error});
    end
    n_checks++;
    if (checksum !== 32'h0) begin n_fail++; $display("FAIL reset_checksum: got %0h required 0", checksum); end
  endtask

  task automatic test_basic();
    clear_mon();
    words[0] = 32'd1; words[1] = 32'd2; words[2] = 32'd3;
    do_start(3);
    n_checks++;
    if (!(busy === 1'b1 && cpu_hold === 1'b1)) begin n_fail++; $display("FAIL basic_hold: busy=%0b cpu_hold=%0b required 1 1", busy, cpu_hold); end
    send_words(3, 1'b0);
    wait_done();
    n_checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_done_busy: busy=%0b cpu_hold=%0b required 0 0", busy, cpu_hold); end
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %0b required 0", error); end
    n_checks++;
    if (checksum !== 32'd6) begin n_fail++; $display("FAIL basic_checksum: got %0d required 6", checksum); end
    n_checks++;
    if (wr_cnt != 128) begin n_fail++; $display("FAIL basic_wr_cnt: got %0d required 128", wr_cnt); end
    n_checks++;
    if (mem[0] !== 32'd1 || mem[1] !== 32'd2 || mem[2] !== 32'd3) begin
      n_fail++; $display("FAIL basic_data: got %0h %0h %0h required 1 2 3", mem[0], mem[1], mem[2]);
    end
    n_checks++;
    if (mem[3] !== 32'h0 || mem[127] !== 32'h0) begin n_fail++; $display("FAIL basic_pad: got %0h %0h required 0 0", mem[3], mem[127]); end
    n_checks++;
    if (mem[128] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL basic_past_end: got %0h required ffffffff", mem[128]); end
    n_checks++;
    if (seq_err != 0 || part_err != 0) begin n_fail++; $display("FAIL basic_write_order: seq_err=%0d part_err=%0d required 0 0", seq_err, part_err); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %0b required 0", done); end
  endtask

  task automatic test_toggle_valid();
    clear_mon();
    words[0] = 32'd11; words[1] = 32'd22; words[2] = 32'd33; words[3] = 32'd44; words[4] = 32'd55;
    do_start(5);
    send_words(5, 1'b1);
    wait_done();
    n_checks++;
    if (wr_cnt != 128 || seq_err != 0) begin n_fail++; $display("FAIL toggle_writes: count=%0d seq_err=%0d required 128 0", wr_cnt, seq_err); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (mem[i] !== words[i]) begin n_fail++; $display("FAIL toggle_data[%0d]: got %0d required %0d", i, mem[i], words[i]); end
    end
    n_checks++;
    if (mem[5] !== 32'h0) begin n_fail++; $display("FAIL toggle_pad: got %0h required 0", mem[5]); end
    n_checks++;
    if (checksum !== 32'd165 || error !== 1'b0) begin n_fail++; $display("FAIL toggle_sum: checksum=%0d error=%0b required 165 0", checksum, error); end
  endtask

  task automatic test_overflow();
    clear_mon();
    do_start(DEPTH + 1);
    wait_done();
    n_checks++;
    if (done_cyc > 2) begin n_fail++; $display("FAIL overflow_latency: got %0d extra cycles required <=2", done_cyc); end
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL overflow_error: got %0b required 1", error); end
    @(negedge clk);
    n_checks++;
    if (wr_cnt != 0) begin n_fail++; $display("FAIL overflow_writes: got %0d required 0", wr_cnt); end
  endtask

  task automatic test_slice_map();
    logic [1:0] slice, exp_slice;
    clear_mon();
    words[0] = 32'hC000_0003;
    do_start(1);
    send_words(1, 1'b0);
    wait_done();
    for (int m = 0; m < NUM_MEM; m++) begin
      slice     = first_wdata[2*m +: 2];
      exp_slice = (m == 0 || m == 15) ? 2'b11 : 2'b00;
      n_checks++;
      if (slice !== exp_slice) begin n_fail++; $display("FAIL slice_dev%0d: got %b required %b", m, slice, exp_slice); end
    end
    n_checks++;
    if (error !== 1'b0 || checksum !== 32'hC000_0003) begin
      n_fail++; $display("FAIL slice_status: error=%0b checksum=%0h required 0 c0000003", error, checksum);
    end
  endtask

  task automatic test_verify_corrupt();
    clear_mon();
    corrupt = 1'b1;
    words[0] = 32'd5; words[1] = 32'd7;
    do_start(2);
    send_words(2, 1'b0);
    wait_done();
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL corrupt_error: got %0b required 1", error); end
    n_checks++;
    if (checksum !== 32'd12 || mem[1] !== 32'd7) begin n_fail++; $display("FAIL corrupt_data: checksum=%0d mem1=%0d required 12 7", checksum, mem[1]); end
    corrupt = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int snap;
    clear_mon();
    words[0] = 32'd9; words[1] = 32'd8; words[2] = 32'd7;
    do_start(10);
    send_words(2, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({|mem_we, busy, cpu_hold, s_ready, done} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: got %b required 00000", {|mem_we, busy, cpu_hold, s_ready, done});
    end
    n_checks++;
    if (checksum !== 32'h0) begin n_fail++; $display("FAIL midreset_checksum: got %0h required 0", checksum); end
    snap = wr_cnt;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (wr_cnt != snap || snap != 2) begin n_fail++; $display("FAIL midreset_writes: got %0d then %0d required 2 2", snap, wr_cnt); end
    clear_mon();
    do_start(3);
    send_words(3, 1'b0);
    wait_done();
    n_checks++;
    if (mem[0] !== 32'd9 || mem[1] !== 32'd8 || mem[2] !== 32'd7 || wr_cnt != 128) begin
      n_fail++; $display("FAIL midreset_reload: got %0d %0d %0d count %0d required 9 8 7 128", mem[0], mem[1], mem[2], wr_cnt);
    end
    n_checks++;
    if (checksum !== 32'd24 || error !== 1'b0) begin n_fail++; $display("FAIL midreset_sum: checksum=%0d error=%0b required 24 0", checksum, error); end
  endtask

  task automatic test_zero_words();
    clear_mon();
    do_start(0);
    wait_done();
    n_checks++;
    if (error !== 1'b0 || checksum !== 32'h0) begin n_fail++; $display("FAIL zero_status: error=%0b checksum=%0h required 0 0", error, checksum); end
    @(negedge clk);
    n_checks++;
    if (wr_cnt != 0) begin n_fail++; $display("FAIL zero_writes: got %0d required 0", wr_cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_toggle_valid();
    test_overflow();
    test_slice_map();
    test_verify_corrupt();
    test_reset_mid_load();
    test_zero_words();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
